instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Upstream instruction feeder for the matrix coprocessor `top`. It holds a small program of 22-bit coprocessor instruction words written by a host, such as the board test wrapper or an HPS bridge. On `start` it replays them in order over a valid/ready handshake, either free-running or one instruction per `step` pulse from a debounced push-button. It replaces hand-indexed instruction arrays with a loadable, restartable program buffer.

## Interface
Parameters:
- `DEPTH`, 16: program buffer entries.
- `AW`, 4: address width, $clog2(DEPTH).
- `IW`, 22: instruction word width; must match the coprocessor.

Ports:
- `clk` input 1: single system clock; all logic on posedge.
- `reset` input 1: asynchronous, active-high reset.
- `wr_en` input 1: host write strobe into the program buffer.
- `wr_addr` input AW: host write address.
- `wr_data` input IW: host write data.
- `prog_len` input AW+1: number of instructions to play; sampled on accepted `start`.
- `start` input 1: one-cycle pulse that begins playback from address 0.
- `stop` input 1: abort playback; highest priority after reset.
- `step_mode` input 1: 1 = one issue per `step`; 0 = free-run.
- `step` input 1: one-cycle advance pulse; already debounced and edge-detected.
- `loop` input 1: at end of program, wrap to address 0 instead of finishing.
- `cop_ready` input 1: coprocessor can accept an instruction.
- `instr_out` output IW: instruction word presented to the coprocessor.
- `instr_valid` output 1: `instr_out` is valid; held until accepted.
- `pc` output AW: address of the current or next instruction.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse when playback ends normally.

## Operation
- Buffer: DEPTH×IW, synchronous read, one write port.
  - Host writes are honoured only in IDLE; writes while `busy` are dropped.
  - Buffer contents are not reset.
- FSM states: IDLE, FETCH, ISSUE, FINISH.
- IDLE
  - On `start`: latch `len = min(prog_len, DEPTH)` and set `pc = 0`.
  - If `len == 0`, go to FINISH with no issue; otherwise go to FETCH.
- FETCH: read mem[pc] for one cycle, then go to ISSUE.
- ISSUE
  - `instr_out = mem[pc]`.
  - `instr_valid` rises when `step_mode == 0`, or when `step_mode == 1` and `step_pend` is set.
  - An instruction is accepted on the cycle where `instr_valid && cop_ready`. On acceptance:
    - clear `step_pend` and drop `instr_valid` next cycle;
    - if `pc == len-1`: with `loop` high, set `pc = 0` and go to FETCH; otherwise go to FINISH;
    - else: `pc++` and go to FETCH.
- FINISH: `done = 1` for one cycle, then go to IDLE.
- `step_pend` flag
  - Set by `step` in any non-IDLE state.
  - Cleared on acceptance and in IDLE.
  - Multiple `step` pulses before an issue count as one.
- `stop` in any state
  - Next state is IDLE; `instr_valid` drops next cycle.
  - No `done` pulse; `pc` is held for inspection.
- `start` while `busy` is ignored.
- `start` and `stop` in the same cycle: `stop` wins.
- `step_mode` may change at any time; it is evaluated each cycle in ISSUE.

## Timing
- Reset values:
  - `instr_out = 0`, `instr_valid = 0`, `pc = 0`;
  - `busy = 0`, `done = 0`, `step_pend = 0`;
  - FSM in IDLE.
- Latency, with `start` at cycle 0 (IDLE):
  - FETCH at cycle 1;
  - `instr_valid` high at cycle 2 (free-run, `cop_ready` = 1).
- Throughput: one instruction per 2 cycles with `cop_ready` held high.
- `instr_out` is stable for the whole time `instr_valid` is high. It keeps its last value when `instr_valid` is low.
- `done` asserts the cycle after the final acceptance, and `busy` falls the cycle after that.
- `len == 0`: `done` at cycle 1, idle at cycle 2.
- All outputs are registered.

## Structure
- Shared package `cop_pkg` holds:
  - `IW = 22`;
  - opcode field slice [3:0];
  - opcode constants `OP_LOAD = 4'b0010` and `OP_SUM = 4'b0011`;
  - FSM state enum `seq_state_t`.
- Sub-module `seq_mem`: DEPTH×IW simple dual-port RAM with sync read, inferable as block RAM.
- FSM, `pc`, length clamp and `step_pend` live in `instr_sequencer`.

## Test plan
- **Free-run:** write 3 words, 0x2FF002, 0x0FF042, 0x200092; `prog_len = 3`; `cop_ready = 1`; `start`.
  - Expect three accepts carrying those words at cycles 2, 4 and 6.
  - Expect `done` at cycle 7 and `busy` low at cycle 8.
- **Backpressure:** same program with `cop_ready` low for 5 cycles in the first ISSUE.
  - `instr_valid` stays high and `instr_out` stays 0x2FF002 throughout; the word is accepted exactly once.
- **Step mode:** `step_mode = 1`, `prog_len = 2`, two `step` pulses spaced 20 cycles apart.
  - Each pulse yields exactly one accept; a double `step` before ISSUE still yields one accept.
- **Loop:** `loop = 1`, `prog_len = 2`, free-run for 10 accepts.
  - Accepted addresses run 0,1,0,1,…; no `done`.
  - Then `stop`: `instr_valid` is low the next cycle, no `done`, and `pc` is held.
- **Boundaries:**
  - `prog_len = 0`: `done` at cycle 1, zero accepts.
  - `prog_len = 20` with DEPTH 16: 16 accepts, then `done`.
  - A write while `busy` leaves the buffer unchanged.
- **Reset mid-ISSUE:** assert `reset` asynchronously.
  - All outputs go to their reset values immediately.
  - After release, `start` replays from address 0.

Source files
------------

// File: rtl/cop_pkg.sv
// Shared definitions for the matrix coprocessor and its instruction feeder:
// instruction width, opcode field, opcode constants and the sequencer FSM states.
package cop_pkg;

    localparam int IW     = 22;
    localparam int OP_MSB = 3;
    localparam int OP_LSB = 0;

    localparam logic [3:0] OP_LOAD = 4'b0010;
    localparam logic [3:0] OP_SUM  = 4'b0011;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_ISSUE  = 2'd2,
        S_FINISH = 2'd3
    } seq_state_t;

    function automatic logic [3:0] opcode_of(input logic [IW-1:0] instr);
        return instr[OP_MSB:OP_LSB];
    endfunction

endpackage

// File: rtl/seq_mem.sv
// Program buffer: simple dual-port RAM, one write port, one registered read port.
// Only the read register is reset; the array contents survive reset.
module seq_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DW    = 22
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // The read register only loads on i_re, so the last word read is held between fetches.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_rdata <= '0;
        end else if (i_re) begin
            o_rdata <= r_mem[i_raddr];
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Replays a host-loaded program of coprocessor instructions over a valid/ready
// handshake, free-running or one instruction per step pulse, with optional looping.
module instr_sequencer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int IW    = 22
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [IW-1:0] wr_data,
    input  logic [AW:0]   prog_len,
    input  logic          start,
    input  logic          stop,
    input  logic          step_mode,
    input  logic          step,
    input  logic          loop,
    input  logic          cop_ready,
    output logic [IW-1:0] instr_out,
    output logic          instr_valid,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          done,
    output logic [1:0]    dbg_state
);
    import cop_pkg::*;

    localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);

    // Handshake: an instruction transfers on a cycle where instr_valid && cop_ready;
    // once raised, instr_valid and instr_out hold until that transfer (or stop/reset).
    seq_state_t    r_state, w_next_state;
    logic [AW-1:0] r_pc, w_pc_next;
    logic [AW:0]   r_len, w_len_next, w_len_clamp;
    logic          r_step_pend, w_step_pend_next;
    logic          r_valid, w_valid_next;
    logic          r_busy, r_done;
    logic          w_accept, w_last, w_fetch, w_mem_we, w_step_ok;
    logic [IW-1:0] w_rdata;

    assign w_len_clamp = (prog_len > LEN_MAX) ? LEN_MAX : prog_len;
    assign w_accept    = (r_state == S_ISSUE) && r_valid && cop_ready;
    assign w_last      = ({1'b0, r_pc} == (r_len - (AW+1)'(1)));
    assign w_fetch     = (r_state == S_FETCH);
    assign w_mem_we    = wr_en && (r_state == S_IDLE);
    assign w_step_ok   = !step_mode || r_step_pend || step;

    seq_mem #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (IW)
    ) u_mem (
        .i_clk   (clk),
        .i_rst   (reset),
        .i_we    (w_mem_we),
        .i_waddr (wr_addr),
        .i_wdata (wr_data),
        .i_re    (w_fetch),
        .i_raddr (r_pc),
        .o_rdata (w_rdata)
    );

    always_comb begin
        w_next_state = r_state;
        w_pc_next    = r_pc;
        w_len_next   = r_len;
        w_valid_next = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_len_next   = w_len_clamp;
                    w_pc_next    = '0;
                    w_next_state = (w_len_clamp == '0) ? S_FINISH : S_FETCH;
                end
            end
            S_FETCH: begin
                w_next_state = S_ISSUE;
                w_valid_next = w_step_ok;
            end
            S_ISSUE: begin
                if (w_accept) begin
                    if (w_last) begin
                        if (loop) begin
                            w_pc_next    = '0;
                            w_next_state = S_FETCH;
                        end else begin
                            w_next_state = S_FINISH;
                        end
                    end else begin
                        w_pc_next    = r_pc + AW'(1);
                        w_next_state = S_FETCH;
                    end
                end else begin
                    w_valid_next = r_valid || w_step_ok;
                end
            end
            S_FINISH: w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
        // Abort keeps pc for inspection and overrides any start in the same cycle.
        if (stop) begin
            w_next_state = S_IDLE;
            w_pc_next    = r_pc;
            w_len_next   = r_len;
            w_valid_next = 1'b0;
        end
    end

    always_comb begin
        w_step_pend_next = r_step_pend;
        if (r_state == S_IDLE || w_next_state == S_IDLE || w_accept) begin
            w_step_pend_next = 1'b0;
        end else if (step) begin
            w_step_pend_next = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_pc        <= '0;
            r_len       <= '0;
            r_step_pend <= 1'b0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_pc        <= w_pc_next;
            r_len       <= w_len_next;
            r_step_pend <= w_step_pend_next;
            r_valid     <= w_valid_next;
            r_busy      <= (w_next_state != S_IDLE);
            r_done      <= (w_next_state == S_FINISH);
        end
    end

    assign instr_out   = w_rdata;
    assign instr_valid = r_valid;
    assign pc          = r_pc;
    assign busy        = r_busy;
    assign done        = r_done;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: cycle table for free-run timing, directed
// corner sequences, and randomized programs checked against an array/queue model.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        reset, wr_en, start, stop, step_mode, step, loop, cop_ready;
    logic [3:0]  wr_addr;
    logic [21:0] wr_data;
    logic [4:0]  prog_len;
    logic [21:0] instr_out;
    logic        instr_valid, busy, done;
    logic [3:0]  pc;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    instr_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .prog_len    (prog_len),
        .start       (start),
        .stop        (stop),
        .step_mode   (step_mode),
        .step        (step),
        .loop        (loop),
        .cop_ready   (cop_ready),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .pc          (pc),
        .busy        (busy),
        .done        (done),
        .dbg_state   (dbg_state)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          done_cnt = 0;
    logic [21:0] model_mem [16];
    logic [21:0] exp_q [$];
    logic [21:0] acc_q [$];
    logic [3:0]  acc_pc_q [$];
    logic        hold_valid = 1'b0;
    logic [21:0] hold_word  = '0;

    typedef struct {
        logic [21:0] instr;
        logic        valid;
        logic [3:0]  pc;
        logic        busy;
        logic        done;
    } vec_t;
    vec_t tbl [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Samples the current cycle (accepts, done, held-valid rule), then advances one clock.
    task automatic tick();
        if (hold_valid) begin
            check("hold_valid_word", 64'({instr_valid, instr_out}), 64'({1'b1, hold_word}));
        end
        if (instr_valid && cop_ready) begin
            acc_q.push_back(instr_out);
            acc_pc_q.push_back(pc);
        end
        if (done) done_cnt++;
        hold_valid = instr_valid && !cop_ready && !stop && !reset;
        hold_word  = instr_out;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_mon();
        acc_q.delete();
        acc_pc_q.delete();
        done_cnt = 0;
    endtask

    task automatic write_word(input logic [3:0] a, input logic [21:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en = 1'b0;
        model_mem[a] = d;
    endtask

    task automatic pulse_start(input logic [4:0] len);
        prog_len = len;
        start    = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_until_done(input string name, input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            tick();
            n++;
        end
        n_checks++;
        if (done_cnt == 0) begin
            n_fail++;
            $display("FAIL %s_timeout: no done within %0d cycles, expected a done pulse", name, budget);
        end
        tick();
    endtask

    initial begin
        int          n;
        int          len;
        int          idx;
        logic [21:0] w, e, d;
        logic [3:0]  p, a;

        tbl[0] = '{22'h000000, 1'b0, 4'd0, 1'b0, 1'b0};
        tbl[1] = '{22'h000000, 1'b0, 4'd0, 1'b1, 1'b0};
        tbl[2] = '{22'h2FF002, 1'b1, 4'd0, 1'b1, 1'b0};
        tbl[3] = '{22'h2FF002, 1'b0, 4'd1, 1'b1, 1'b0};
        tbl[4] = '{22'h0FF042, 1'b1, 4'd1, 1'b1, 1'b0};
        tbl[5] = '{22'h0FF042, 1'b0, 4'd2, 1'b1, 1'b0};
        tbl[6] = '{22'h200092, 1'b1, 4'd2, 1'b1, 1'b0};
        tbl[7] = '{22'h200092, 1'b0, 4'd2, 1'b1, 1'b1};
        tbl[8] = '{22'h200092, 1'b0, 4'd2, 1'b0, 1'b0};

        reset = 1'b1; wr_en = 1'b0; start = 1'b0; stop = 1'b0; step_mode = 1'b0;
        step = 1'b0; loop = 1'b0; cop_ready = 1'b0; wr_addr = '0; wr_data = '0; prog_len = '0;
        for (int k = 0; k < 16; k++) model_mem[k] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 64'({instr_out, instr_valid, pc, busy, done, dbg_state}), 64'(0));
        reset = 1'b0;
        tick();

        // Free-run timing table
        write_word(4'd0, 22'h2FF002);
        write_word(4'd1, 22'h0FF042);
        write_word(4'd2, 22'h200092);
        cop_ready = 1'b1;
        prog_len  = 5'd3;
        clear_mon();
        for (int i = 0; i < 9; i++) begin
            check($sformatf("freerun_c%0d", i),
                  64'({instr_out, instr_valid, pc, busy, done}),
                  64'({tbl[i].instr, tbl[i].valid, tbl[i].pc, tbl[i].busy, tbl[i].done}));
            start = (i == 0);
            tick();
        end
        start = 1'b0;
        check("freerun_count", 64'(acc_q.size()), 64'(3));
        check("freerun_done_cnt", 64'(done_cnt), 64'(1));
        if (acc_q.size() == 3) begin
            for (int k = 0; k < 3; k++) check($sformatf("freerun_word%0d", k), 64'(acc_q[k]), 64'(model_mem[k]));
        end

        // Backpressure in the first ISSUE
        cop_ready = 1'b0;
        clear_mon();
        pulse_start(5'd3);
        tick();
        for (int j = 0; j < 5; j++) begin
            check("bp_hold", 64'({instr_valid, instr_out}), 64'({1'b1, 22'h2FF002}));
            tick();
        end
        cop_ready = 1'b1;
        run_until_done("bp", 40);
        check("bp_count", 64'(acc_q.size()), 64'(3));
        n = 0;
        foreach (acc_q[k]) if (acc_q[k] == 22'h2FF002) n++;
        check("bp_first_once", 64'(n), 64'(1));

        // Step mode, including a repeated step before the issue is taken
        step_mode = 1'b1;
        cop_ready = 1'b0;
        clear_mon();
        pulse_start(5'd2);
        repeat (10) tick();
        check("step_no_issue", 64'({instr_valid, busy}), 64'({1'b0, 1'b1}));
        step = 1'b1; tick(); step = 1'b0;
        repeat (2) tick();
        step = 1'b1; tick(); step = 1'b0;
        repeat (2) tick();
        cop_ready = 1'b1;
        repeat (20) tick();
        check("step_one_accept", 64'(acc_q.size()), 64'(1));
        step = 1'b1; tick(); step = 1'b0;
        repeat (20) tick();
        check("step_two_accepts", 64'(acc_q.size()), 64'(2));
        check("step_done_cnt", 64'(done_cnt), 64'(1));
        if (acc_q.size() == 2) check("step_word1", 64'(acc_q[1]), 64'(model_mem[1]));
        step_mode = 1'b0;

        // Loop, then stop
        loop = 1'b1;
        cop_ready = 1'b1;
        clear_mon();
        pulse_start(5'd2);
        n = 0;
        while (acc_q.size() < 11 && n < 60) begin
            tick();
            n++;
        end
        check("loop_count", 64'(acc_q.size()), 64'(11));
        if (acc_q.size() >= 10) begin
            for (int k = 0; k < 10; k++) begin
                check($sformatf("loop_pc%0d", k), 64'(acc_pc_q[k]), 64'(k % 2));
                check($sformatf("loop_word%0d", k), 64'(acc_q[k]), 64'(model_mem[k % 2]));
            end
        end
        check("loop_no_done", 64'(done_cnt), 64'(0));
        cop_ready = 1'b0;
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_outputs", 64'({instr_valid, busy, done, pc}), 64'({1'b0, 1'b0, 1'b0, 4'd1}));
        repeat (3) tick();
        check("stop_no_done", 64'(done_cnt), 64'(0));
        loop = 1'b0;

        // prog_len == 0
        cop_ready = 1'b1;
        clear_mon();
        pulse_start(5'd0);
        check("len0_c1", 64'({done, busy}), 64'({1'b1, 1'b1}));
        tick();
        check("len0_c2", 64'({done, busy, instr_valid}), 64'(0));
        check("len0_accepts", 64'(acc_q.size()), 64'(0));

        // prog_len beyond DEPTH clamps to 16
        for (int k = 0; k < 16; k++) write_word(4'(k), 22'($urandom()));
        clear_mon();
        pulse_start(5'd20);
        run_until_done("len20", 100);
        check("len20_count", 64'(acc_q.size()), 64'(16));
        if (acc_q.size() == 16) begin
            for (int k = 0; k < 16; k++) check($sformatf("len20_word%0d", k), 64'(acc_q[k]), 64'(model_mem[k]));
        end

        // Write while busy is dropped
        clear_mon();
        pulse_start(5'd1);
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = ~model_mem[0];
        tick();
        wr_en = 1'b0;
        run_until_done("busy_wr", 20);
        clear_mon();
        pulse_start(5'd1);
        run_until_done("busy_wr_replay", 20);
        check("busy_wr_count", 64'(acc_q.size()), 64'(1));
        if (acc_q.size() == 1) check("busy_wr_word", 64'(acc_q[0]), 64'(model_mem[0]));

        // Asynchronous reset in the middle of ISSUE
        cop_ready = 1'b0;
        clear_mon();
        pulse_start(5'd3);
        tick();
        check("pre_reset_valid", 64'(instr_valid), 64'(1));
        #2 reset = 1'b1;
        #1 check("async_reset", 64'({instr_out, instr_valid, pc, busy, done}), 64'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        hold_valid = 1'b0;
        cop_ready = 1'b1;
        clear_mon();
        pulse_start(5'd3);
        run_until_done("post_reset", 40);
        check("post_reset_count", 64'(acc_q.size()), 64'(3));
        if (acc_q.size() == 3) begin
            check("post_reset_pc0", 64'(acc_pc_q[0]), 64'(0));
            check("post_reset_word0", 64'(acc_q[0]), 64'(model_mem[0]));
        end

        // Randomized programs against the array/queue model
        for (int it = 0; it < 25; it++) begin
            for (int k = 0; k < 4; k++) begin
                a = 4'($urandom_range(0, 15));
                d = 22'($urandom());
                write_word(a, d);
            end
            len = $urandom_range(0, 20);
            step_mode = 1'($urandom_range(0, 1));
            exp_q.delete();
            for (int k = 0; k < ((len > 16) ? 16 : len); k++) exp_q.push_back(model_mem[k]);
            cop_ready = ($urandom_range(0, 3) != 0);
            clear_mon();
            pulse_start(5'(len));
            idx = 0;
            n = 0;
            while (done_cnt == 0 && n < 800) begin
                wr_en     = ($urandom_range(0, 3) == 0);
                wr_addr   = 4'($urandom_range(0, 15));
                wr_data   = 22'($urandom());
                step      = ($urandom_range(0, 3) == 0);
                cop_ready = ($urandom_range(0, 3) != 0);
                tick();
                n++;
                while (acc_q.size() > 0) begin
                    w = acc_q.pop_front();
                    p = acc_pc_q.pop_front();
                    if (exp_q.size() == 0) begin
                        check("rand_extra_accept", 64'(w), 64'({1'b1, 22'h0}));
                    end else begin
                        e = exp_q.pop_front();
                        check("rand_word", 64'(w), 64'(e));
                        check("rand_pc", 64'(p), 64'(idx));
                        idx++;
                    end
                end
            end
            wr_en = 1'b0;
            step  = 1'b0;
            check("rand_done", 64'(done_cnt), 64'(1));
            check("rand_remaining", 64'(exp_q.size()), 64'(0));
            tick();
        end
        step_mode = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
